// File: rtl/inst_align_pkg.sv
// rtl/inst_align_pkg.sv - shared state encodings and opcode helpers for the instruction aligner
package inst_align_pkg;

    typedef enum logic [2:0] {
        S_LOOK  = 3'd0,
        S_WAIT0 = 3'd1,
        S_WAIT1 = 3'd2,
        S_OUT   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [1:0] OPC_32 = 2'b11;

    // Only the two low opcode bits of a halfword decide its length.
    function automatic logic is_comp(input logic [1:0] hw);
        return hw != OPC_32;
    endfunction

endpackage

// File: rtl/inst_align_extract.sv
// rtl/inst_align_extract.sv - combinational instruction selection from word, halfword or spill
module inst_align_extract
    import inst_align_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [15:0] i_spill,
    input  logic        i_hi,
    input  logic        i_cross,
    output logic [31:0] o_inst,
    output logic        o_com,
    output logic        o_need_next
);

    always_comb begin
        o_inst      = '0;
        o_com       = 1'b0;
        o_need_next = 1'b0;
        if (i_cross) begin
            o_inst = {i_word[15:0], i_spill};
        end else if (!i_hi) begin
            o_com  = is_comp(i_word[1:0]);
            o_inst = o_com ? {16'h0, i_word[15:0]} : i_word;
        end else begin
            // Upper halfword of a 32-bit instruction continues in the next word.
            o_com = is_comp(i_word[17:16]);
            if (o_com) begin
                o_inst = {16'h0, i_word[31:16]};
            end else begin
                o_need_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/inst_align.sv
// rtl/inst_align.sv - aligns 16/32-bit instructions from word memory and hands them to decode
module inst_align
    import inst_align_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter bit BUF_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] fet_pc_i,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              ali_valid_o,
    input  logic              dec_ready_i,
    output logic [31:0]       ali_inst_o,
    output logic [ADDR_W-1:0] ali_pc_o,
    output logic              ali_com_o,
    output logic              ali_fet_en_o
);

    state_t            r_state;
    state_t            w_nxt;
    logic              r_buf_vld;
    logic [31:0]       r_buf_word;
    logic [ADDR_W-1:0] r_buf_addr;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_spill;
    logic              r_drop;
    logic              r_valid;
    logic [31:0]       r_inst;
    logic              r_com;

    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_word;
    logic [ADDR_W-1:0] w_next_word;
    logic              w_hit;
    logic              w_outstanding;
    logic [31:0]       w_ext_word;
    logic [31:0]       w_ext_inst;
    logic              w_ext_com;
    logic              w_need_next;
    logic              w_req;
    logic [ADDR_W-1:0] w_addr;
    logic              w_buf_load;
    logic              w_spill_load;
    logic              w_out_load;
    logic              w_unused;

    // Fetch holds its PC until enabled, but r_pc keeps the lookup PC across waits.
    assign w_pc          = (r_state == S_LOOK) ? fet_pc_i : r_pc;
    assign w_pc_word     = {w_pc[ADDR_W-1:2], 2'b00};
    assign w_next_word   = w_pc_word + ADDR_W'(4);
    assign w_hit         = BUF_EN && r_buf_vld && (r_buf_addr == w_pc_word);
    assign w_outstanding = (r_state == S_WAIT0) || (r_state == S_WAIT1);
    assign w_ext_word    = (r_state == S_LOOK) ? r_buf_word : mem_rdata_i;
    assign w_unused      = w_pc[0];

    inst_align_extract u_extract (
        .i_word      (w_ext_word),
        .i_spill     (r_spill),
        .i_hi        (w_pc[1]),
        .i_cross     (r_state == S_WAIT1),
        .o_inst      (w_ext_inst),
        .o_com       (w_ext_com),
        .o_need_next (w_need_next)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_LOOK;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_state;
        if (flush_i) begin
            if (w_outstanding || r_state == S_DRAIN) begin
                w_nxt = mem_rvalid_i ? S_LOOK : S_DRAIN;
            end else begin
                w_nxt = S_LOOK;
            end
        end else begin
            case (r_state)
                S_LOOK:  w_nxt = !w_hit ? S_WAIT0 : (w_need_next ? S_WAIT1 : S_OUT);
                S_WAIT0: if (mem_rvalid_i) w_nxt = w_need_next ? S_WAIT1 : S_OUT;
                S_WAIT1: if (mem_rvalid_i) w_nxt = S_OUT;
                S_OUT:   if (dec_ready_i) w_nxt = S_LOOK;
                S_DRAIN: if (mem_rvalid_i || !r_drop) w_nxt = S_LOOK;
                default: w_nxt = S_LOOK;
            endcase
        end
    end

    always_comb begin
        w_req        = 1'b0;
        w_addr       = w_next_word;
        w_buf_load   = 1'b0;
        w_spill_load = 1'b0;
        if (!flush_i) begin
            case (r_state)
                S_LOOK: begin
                    if (!w_hit) begin
                        w_req  = 1'b1;
                        w_addr = w_pc_word;
                    end else if (w_need_next) begin
                        w_req        = 1'b1;
                        w_spill_load = 1'b1;
                    end
                end
                S_WAIT0: begin
                    if (mem_rvalid_i) begin
                        w_buf_load = 1'b1;
                        if (w_need_next) begin
                            w_req        = 1'b1;
                            w_spill_load = 1'b1;
                        end
                    end
                end
                S_WAIT1: w_buf_load = mem_rvalid_i;
                default: ;
            endcase
        end
        w_out_load = (w_nxt == S_OUT) && (r_state != S_OUT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_buf_vld  <= 1'b0;
            r_buf_word <= '0;
            r_buf_addr <= '0;
            r_pc       <= '0;
            r_spill    <= '0;
            r_drop     <= 1'b0;
            r_valid    <= 1'b0;
            r_inst     <= '0;
            r_com      <= 1'b0;
        end else begin
            if (flush_i) begin
                r_buf_vld <= 1'b0;
            end else if (w_buf_load) begin
                r_buf_vld  <= 1'b1;
                r_buf_word <= mem_rdata_i;
                r_buf_addr <= (r_state == S_WAIT0) ? w_pc_word : w_next_word;
            end
            if (r_state == S_LOOK && !flush_i) begin
                r_pc <= fet_pc_i;
            end
            if (w_spill_load) begin
                r_spill <= w_ext_word[31:16];
            end
            if (flush_i && w_outstanding && !mem_rvalid_i) begin
                r_drop <= 1'b1;
            end else if (r_state == S_DRAIN && mem_rvalid_i) begin
                r_drop <= 1'b0;
            end
            if (flush_i) begin
                r_valid <= 1'b0;
            end else if (w_out_load) begin
                r_valid <= 1'b1;
                r_inst  <= w_ext_inst;
                r_com   <= w_ext_com;
            end else if (r_state == S_OUT && dec_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign mem_req_o    = w_req & ~rst_i;
    assign mem_addr_o   = (w_req & ~rst_i) ? w_addr : '0;
    assign ali_valid_o  = r_valid;
    assign ali_inst_o   = r_inst;
    assign ali_pc_o     = r_pc;
    assign ali_com_o    = r_com;
    assign ali_fet_en_o = ~rst_i & ((r_valid & dec_ready_i) | flush_i);

endmodule

// File: tb/tb_inst_align.sv
// tb/tb_inst_align.sv - scoreboard bench for inst_align with a latency-programmable memory and fetch model
module tb_inst_align;
    import inst_align_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fet_pc;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ali_valid;
    logic        dec_ready;
    logic [31:0] ali_inst;
    logic [31:0] ali_pc;
    logic        ali_com;
    logic        ali_fet_en;

    inst_align #(.ADDR_W(32), .BUF_EN(1'b1)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fet_pc_i     (fet_pc),
        .flush_i      (flush),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .ali_valid_o  (ali_valid),
        .dec_ready_i  (dec_ready),
        .ali_inst_o   (ali_inst),
        .ali_pc_o     (ali_pc),
        .ali_com_o    (ali_com),
        .ali_fet_en_o (ali_fet_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        com;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          acc_cyc[$];
    logic [31:0] mem [0:63];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    int          first_req_cyc = -1;
    int          first_val_cyc = -1;
    int          req_cnt = 0;
    bit          fe_s = 0;
    bit          fl_s = 0;
    bit          com_s = 0;
    logic [31:0] flush_pc = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] inst, input logic [31:0] pc, input logic com);
        exp_t e;
        e.inst = inst;
        e.pc   = pc;
        e.com  = com;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input logic [31:0] pc, input int l);
        rst = 1'b1;
        flush = 1'b0;
        dec_ready = 1'b0;
        mem_rvalid = 1'b0;
        pend = 0;
        lat = l;
        fet_pc = pc;
        fe_s = 0;
        fl_s = 0;
        exp_q.delete();
        addr_q.delete();
        acc_cyc.delete();
        first_req_cyc = -1;
        first_val_cyc = -1;
        req_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        #1 dec_ready = 1'b0;
    endtask

    // Memory responder and fetch PC model, both driven just after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            mem_rvalid = 1'b0;
            if (pend && !rst) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem[pend_addr[7:2]];
                    pend = 0;
                end
            end
            if (!rst) begin
                if (fl_s) fet_pc = flush_pc;
                else if (fe_s) fet_pc = fet_pc + (com_s ? 32'd2 : 32'd4);
            end
        end
    end

    // Output monitor on the falling edge.
    initial begin
        exp_t e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (!rst) begin
                fe_s  = ali_fet_en;
                fl_s  = flush;
                com_s = ali_com;
                if (mem_req) begin
                    chk("one_outstanding", 64'(pend), 64'd0);
                    req_cnt++;
                    if (first_req_cyc < 0) first_req_cyc = cyc;
                    if (addr_q.size() > 0) begin
                        a = addr_q.pop_front();
                        chk("req_addr", 64'(mem_addr), 64'(a));
                    end
                    pend = 1;
                    pend_cnt = lat;
                    pend_addr = mem_addr;
                end
                if (ali_valid && first_val_cyc < 0) first_val_cyc = cyc;
                if (ali_valid && dec_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("inst", 64'(ali_inst), 64'(e.inst));
                    chk("pc", 64'(ali_pc), 64'(e.pc));
                    chk("com", 64'(ali_com), 64'(e.com));
                    chk("fet_en_accept", 64'(ali_fet_en), 64'd1);
                    acc_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 64; i++) mem[i] = 32'h00000013;
        rst = 1'b1;
        flush = 1'b0;
        dec_ready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        fet_pc = '0;
        #2;
        chk("rst_valid", 64'(ali_valid), 64'd0);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_inst", 64'(ali_inst), 64'd0);
        chk("rst_fet_en", 64'(ali_fet_en), 64'd0);
        chk("rst_state", 64'(dut.r_state), 64'(S_LOOK));

        // Single 32-bit instruction, latency 1
        mem[0] = 32'h00500093;
        do_reset(32'h0, 1);
        addr_q.push_back(32'h0);
        push_exp(32'h00500093, 32'h0, 1'b0);
        dec_ready = 1'b1;
        wait_drain(50);
        chk("s1_latency", 64'(first_val_cyc - first_req_cyc), 64'd2);
        chk("s1_addr_left", 64'(addr_q.size()), 64'd0);

        // Two compressed instructions, second from the buffer
        mem[0] = 32'h45814501;
        do_reset(32'h0, 2);
        addr_q.push_back(32'h0);
        push_exp(32'h00004501, 32'h0, 1'b1);
        push_exp(32'h00004581, 32'h2, 1'b1);
        dec_ready = 1'b1;
        wait_drain(60);
        chk("s2_req_count", 64'(req_cnt), 64'd1);
        if (acc_cyc.size() == 2) chk("s2_hit_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'd2);
        else chk("s2_accepts", 64'(acc_cyc.size()), 64'd2);

        // Word-crossing 32-bit instruction, then a C instruction from the new buffer
        mem[0] = 32'h00934501;
        mem[1] = 32'hABCD0513;
        do_reset(32'h2, 2);
        addr_q.push_back(32'h0);
        addr_q.push_back(32'h4);
        push_exp(32'h05130093, 32'h2, 1'b0);
        push_exp(32'h0000ABCD, 32'h6, 1'b1);
        dec_ready = 1'b1;
        wait_drain(80);
        chk("s3_latency", 64'(first_val_cyc - first_req_cyc), 64'd5);
        chk("s3_req_count", 64'(req_cnt), 64'd2);
        chk("s3_addr_left", 64'(addr_q.size()), 64'd0);

        // Backpressure holds the output steady
        mem[0] = 32'h00500093;
        do_reset(32'h0, 1);
        push_exp(32'h00500093, 32'h0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ali_valid && n < 50);
        chk("s4_valid_seen", 64'(ali_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("s4_hold_valid", 64'(ali_valid), 64'd1);
            chk("s4_hold_inst", 64'(ali_inst), 64'h00500093);
            chk("s4_hold_pc", 64'(ali_pc), 64'd0);
            chk("s4_hold_fet_en", 64'(ali_fet_en), 64'd0);
        end
        @(posedge clk);
        #1 dec_ready = 1'b1;
        wait_drain(20);

        // Flush while waiting: stale response drained, new PC fetched
        mem[0] = 32'h00500093;
        mem[8] = 32'h00a00113;
        flush_pc = 32'h20;
        do_reset(32'h0, 3);
        addr_q.push_back(32'h0);
        addr_q.push_back(32'h20);
        push_exp(32'h00a00113, 32'h20, 1'b0);
        dec_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 50);
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("s5_fet_en_flush", 64'(ali_fet_en), 64'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("s5_drain_state", 64'(dut.r_state), 64'(S_DRAIN));
        wait_drain(80);
        chk("s5_addr_left", 64'(addr_q.size()), 64'd0);

        // Asynchronous reset in the middle of the second word wait
        do_reset(32'h2, 3);
        mem[0] = 32'h00934501;
        mem[1] = 32'hABCD0513;
        dec_ready = 1'b1;
        n = 0;
        while (req_cnt < 2 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk("s6_pre_state", 64'(dut.r_state), 64'(S_WAIT1));
        #1;
        rst = 1'b1;
        pend = 0;
        mem_rvalid = 1'b0;
        #1;
        chk("s6_rst_req", 64'(mem_req), 64'd0);
        chk("s6_rst_valid", 64'(ali_valid), 64'd0);
        chk("s6_rst_fet_en", 64'(ali_fet_en), 64'd0);
        chk("s6_rst_state", 64'(dut.r_state), 64'(S_LOOK));
        chk("s6_rst_buf_vld", 64'(dut.r_buf_vld), 64'd0);
        do_reset(32'h2, 1);
        chk("s6_rel_buf_vld", 64'(dut.r_buf_vld), 64'd0);
        addr_q.push_back(32'h0);
        addr_q.push_back(32'h4);
        push_exp(32'h05130093, 32'h2, 1'b0);
        dec_ready = 1'b1;
        wait_drain(60);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
